fpu_mul_axil_regs: RTL and testbench
====================================

Name: fpu_mul_axil_regs

Overview:
- AXI4-Lite slave register front end that feeds operands to the registered FP32 multiplier and captures its result.
- Upstream neighbour of the multiplier: holds operand registers and a START/DONE sequencer that waits out the multiplier's pipeline latency, then latches the product for software readback.
- One instance per multiplier; sits between the interconnect and the datapath.

Parameters:
- ADDR_W, 5, AXI-Lite byte-address width; registers are word aligned.
- LATENCY, 1, clock cycles from operand change to valid multiplier result; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  ADDR_W  write address
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  ADDR_W  read address
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data ready
- op_a  out  32  operand A to the multiplier
- op_b  out  32  operand B to the multiplier
- mul_result  in  32  multiplier output

Behaviour:
- Reset: clk with asynchronous active-low rst_n. All ready, valid, resp and rdata outputs are 0. op_a and op_b are 0. All registers are 0. FSM is IDLE. Reset mid-operation aborts the operation with no residual state.
- Register map (byte offset):
  - 0x00 OPA: RW.
  - 0x04 OPB: RW.
  - 0x08 CTRL: bit0 START, write-1 self-clearing, reads 0.
  - 0x0C STATUS: bit0 DONE (RO), bit1 BUSY (RO), bit2 OVR (sticky, write-1-to-clear).
  - 0x10 RESULT: RO.
- Write channel:
  - AW and W are accepted independently, each into a one-entry holding register. awready and wready are high when their holder is empty and bvalid=0.
  - The write commits on the edge where both holders are full. The holders clear and bvalid rises on the next cycle. bvalid holds until bready.
  - wstrb applies per byte to OPA and OPB. CTRL and STATUS act on wstrb[0] only.
  - Response codes:
    - Writes to RESULT or an unmapped offset have no effect and return BRESP=2'b10 (SLVERR).
    - Writes to STATUS bit0 or bit1 are ignored and return OKAY.
    - All other writes return OKAY.
- Read channel:
  - arready = !rvalid. On the AR handshake, rdata and rresp are registered and rvalid rises on the next cycle, holding until rready.
  - Unmapped offset: rdata=0, rresp=SLVERR.
  - A read in the same cycle as a write commit returns the pre-write value.
- Sequencer FSM:
  - IDLE → RUN on a START commit. On that edge:
    - op_a←OPA and op_b←OPB (shadow copies; later OPA/OPB writes do not disturb the running operation).
    - A down-counter loads LATENCY.
    - DONE clears.
    - BUSY sets.
  - RUN: the counter decrements each cycle. At the edge where the counter equals 0:
    - RESULT←mul_result.
    - DONE sets.
    - BUSY clears.
    - FSM returns to IDLE.
  - Net latency: RESULT and DONE are valid LATENCY+1 edges after the START commit edge.
- START while BUSY, including the final capture edge: ignored, OVR sets, and the running operation is unaffected.
- START and an OVR W1C in the same write: OVR clears first, then the START rule applies.
- op_a and op_b hold their value between operations.

Optional Feature:
- Macro FPU_MUL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - CTRL bit1 becomes IRQ_EN (RW).
  - irq = DONE & IRQ_EN, registered; reset 0.
  - Clears when DONE clears or IRQ_EN is written 0.
- Undefined: no irq port, CTRL bit1 reads 0, writes to it are ignored.

Decomposition:
- Package fpu_mul_pkg holds:
  - register offsets (OFF_OPA, OFF_OPB, OFF_CTRL, OFF_STATUS, OFF_RESULT),
  - STATUS/CTRL bit indices,
  - RESP_OKAY and RESP_SLVERR,
  - the sequencer state enum (IDLE, RUN).
- One sub-module is natural: fpu_mul_seq, containing the FSM, the latency counter, shadow loading and result capture. The AXI-Lite decode stays in the top module.

Test Plan:
- OPA=0x40000000 (2.0), OPB=0x40400000 (3.0), START → DONE=1 after LATENCY+1 edges; RESULT=0x40C00000; BUSY=0.
- AW issued 3 cycles before W, then W; B held with bready=0 for 4 cycles → single commit, bvalid stable, one OKAY, no second write.
- START, then START again on the next cycle → OVR=1, RESULT equals the first product. Write STATUS=0x4 → OVR=0.
- Write OPA=0x3F800000 during RUN → RESULT uses the old shadow; op_a is unchanged until the next START.
- Read 0x14 → rresp=2'b10, rdata=0. Write 0x10 → bresp=2'b10, RESULT unchanged.
- Assert rst_n=0 mid-RUN → all outputs 0 immediately; after release, STATUS=0 and the next START completes normally.

Source files
------------

// File: rtl/fpu_mul_pkg.sv
// Shared definitions for the FP32 multiplier register front end:
// register offsets, bit positions, AXI response codes and the sequencer state.
package fpu_mul_pkg;

   localparam logic [31:0] OFF_OPA    = 32'h00;
   localparam logic [31:0] OFF_OPB    = 32'h04;
   localparam logic [31:0] OFF_CTRL   = 32'h08;
   localparam logic [31:0] OFF_STATUS = 32'h0C;
   localparam logic [31:0] OFF_RESULT = 32'h10;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STAT_DONE_BIT   = 0;
   localparam int STAT_BUSY_BIT   = 1;
   localparam int STAT_OVR_BIT    = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      IDLE,
      RUN
   } seq_state_e;

   typedef enum logic [2:0] {
      SEL_OPA,
      SEL_OPB,
      SEL_CTRL,
      SEL_STATUS,
      SEL_RESULT,
      SEL_NONE
   } reg_sel_e;

   // Registers are word aligned, so the two low address bits are ignored.
   function automatic reg_sel_e decode_addr(input logic [31:0] byte_addr);
      reg_sel_e sel;
      case ({byte_addr[31:2], 2'b00})
         OFF_OPA:    sel = SEL_OPA;
         OFF_OPB:    sel = SEL_OPB;
         OFF_CTRL:   sel = SEL_CTRL;
         OFF_STATUS: sel = SEL_STATUS;
         OFF_RESULT: sel = SEL_RESULT;
         default:    sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fpu_mul_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the
// multiplier register block (slave).
interface fpu_mul_axil_regs_if #(
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/fpu_mul_seq.sv
// START/DONE sequencer: snapshots the operands into the multiplier inputs,
// waits out the multiplier latency, then captures the product.
module fpu_mul_seq
   import fpu_mul_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic [31:0] mul_result,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);
   localparam int CNT_W = 4;

   seq_state_e       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      op_a_reg, op_a_next;
   logic [31:0]      op_b_reg, op_b_next;
   logic [31:0]      result_reg, result_next;
   logic             done_reg, done_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         op_a_reg   <= op_a_next;
         op_b_reg   <= op_b_next;
         result_reg <= result_next;
         done_reg   <= done_next;
      end
   end

   // A START arriving while in RUN is dropped here; the caller flags it as overrun.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      op_a_next   = op_a_reg;
      op_b_next   = op_b_reg;
      result_next = result_reg;
      done_next   = done_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               op_a_next  = opa;
               op_b_next  = opb;
               cnt_next   = CNT_W'(LATENCY);
               done_next  = 1'b0;
            end
         end
         RUN: begin
            if (cnt_reg == '0) begin
               result_next = mul_result;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign op_a   = op_a_reg;
   assign op_b   = op_b_reg;
   assign result = result_reg;
   assign done   = done_reg;
   assign busy   = (state_reg == RUN);

endmodule

// File: rtl/fpu_mul_axil_regs.sv
// AXI4-Lite register front end for the registered FP32 multiplier.
// Optional FPU_MUL_IRQ_EN adds CTRL.IRQ_EN and a registered irq output.
module fpu_mul_axil_regs
   import fpu_mul_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   fpu_mul_axil_regs_if.slave  axil,
   output logic [31:0]         op_a,
   output logic [31:0]         op_b,
   input  logic [31:0]         mul_result
`ifdef FPU_MUL_IRQ_EN
   ,
   output logic                irq
`endif
);
   logic              active_reg;
   logic              aw_full_reg;
   logic [ADDR_W-1:0] aw_addr_reg;
   logic              w_full_reg;
   logic [31:0]       w_data_reg;
   logic [3:0]        w_strb_reg;
   logic              bvalid_reg;
   logic [1:0]        bresp_reg;
   logic              rvalid_reg;
   logic [31:0]       rdata_reg;
   logic [1:0]        rresp_reg;
   logic [31:0]       opa_reg;
   logic [31:0]       opb_reg;
   logic              ovr_reg;
   logic              irq_en;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic        start_req, ovr_clr;
   reg_sel_e    wr_sel, rd_sel;
   logic [31:0] wmask;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic [31:0] result;
   logic        seq_done, seq_busy;

   // Readies stay low until the first clock after reset release.
   assign axil.awready = active_reg & ~aw_full_reg & ~bvalid_reg;
   assign axil.wready  = active_reg & ~w_full_reg  & ~bvalid_reg;
   assign axil.arready = active_reg & ~rvalid_reg;
   assign axil.bvalid  = bvalid_reg;
   assign axil.bresp   = bresp_reg;
   assign axil.rvalid  = rvalid_reg;
   assign axil.rdata   = rdata_reg;
   assign axil.rresp   = rresp_reg;

   assign aw_hs  = axil.awvalid & axil.awready;
   assign w_hs   = axil.wvalid  & axil.wready;
   assign ar_hs  = axil.arvalid & axil.arready;
   assign commit = aw_full_reg & w_full_reg;

   assign wr_sel = decode_addr(32'(aw_addr_reg));
   assign rd_sel = decode_addr(32'(axil.araddr));

   assign start_req = commit && (wr_sel == SEL_CTRL) && w_strb_reg[0]
                      && w_data_reg[CTRL_START_BIT];
   assign ovr_clr   = commit && (wr_sel == SEL_STATUS) && w_strb_reg[0]
                      && w_data_reg[STAT_OVR_BIT];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wmask[gi*8 +: 8] = {8{w_strb_reg[gi]}};
      end
   endgenerate

   fpu_mul_seq #(
      .LATENCY (LATENCY)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_req),
      .opa        (opa_reg),
      .opb        (opb_reg),
      .mul_result (mul_result),
      .op_a       (op_a),
      .op_b       (op_b),
      .result     (result),
      .done       (seq_done),
      .busy       (seq_busy)
   );

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (rd_sel)
         SEL_OPA:    rd_data = opa_reg;
         SEL_OPB:    rd_data = opb_reg;
         SEL_CTRL:   rd_data[CTRL_IRQ_EN_BIT] = irq_en;
         SEL_STATUS: begin
            rd_data[STAT_DONE_BIT] = seq_done;
            rd_data[STAT_BUSY_BIT] = seq_busy;
            rd_data[STAT_OVR_BIT]  = ovr_reg;
         end
         SEL_RESULT: rd_data = result;
         default:    rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg  <= 1'b0;
         aw_full_reg <= 1'b0;
         aw_addr_reg <= '0;
         w_full_reg  <= 1'b0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
         opa_reg     <= '0;
         opb_reg     <= '0;
         ovr_reg     <= 1'b0;
      end else begin
         active_reg <= 1'b1;
         if (commit) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= (wr_sel == SEL_RESULT || wr_sel == SEL_NONE)
                           ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_hs) begin
               aw_full_reg <= 1'b1;
               aw_addr_reg <= axil.awaddr;
            end
            if (w_hs) begin
               w_full_reg <= 1'b1;
               w_data_reg <= axil.wdata;
               w_strb_reg <= axil.wstrb;
            end
            if (bvalid_reg && axil.bready) begin
               bvalid_reg <= 1'b0;
            end
         end

         if (commit && wr_sel == SEL_OPA) begin
            opa_reg <= (opa_reg & ~wmask) | (w_data_reg & wmask);
         end
         if (commit && wr_sel == SEL_OPB) begin
            opb_reg <= (opb_reg & ~wmask) | (w_data_reg & wmask);
         end

         // Clear is applied before the overrun set, so a set in the same cycle wins.
         ovr_reg <= (ovr_reg & ~ovr_clr) | (start_req & seq_busy);

         if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_resp;
         end else if (rvalid_reg && axil.rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

`ifdef FPU_MUL_IRQ_EN
   logic irq_en_reg;
   logic irq_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_reg <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         if (commit && wr_sel == SEL_CTRL && w_strb_reg[0]) begin
            irq_en_reg <= w_data_reg[CTRL_IRQ_EN_BIT];
         end
         irq_reg <= seq_done & irq_en_reg;
      end
   end

   assign irq_en = irq_en_reg;
   assign irq    = irq_reg;
`else
   assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_mul_axil_regs.sv
// Randomized self-checking bench for fpu_mul_axil_regs against a
// cycle-stamped behavioural model of the register map and sequencer.
module tb_fpu_mul_axil_regs;
   localparam int ADDR_W = 5;
   localparam int LAT    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] op_a, op_b, mul_result;
`ifdef FPU_MUL_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   fpu_mul_axil_regs_if #(.ADDR_W(ADDR_W)) axil ();

   fpu_mul_axil_regs #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .axil       (axil),
      .op_a       (op_a),
      .op_b       (op_b),
      .mul_result (mul_result)
`ifdef FPU_MUL_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   // Truncating FP32 multiply for normal operands; stands in for the datapath.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      int          e;
      logic [22:0] f;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         f = m[46:24];
         e++;
      end else begin
         f = m[45:23];
      end
      return {a[31] ^ b[31], 8'(e), f};
   endfunction

   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= fmul(op_a, op_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_result = pipe[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model state; an operation started at commit edge m_s is busy through
   // edge m_s+LAT and done from edge m_s+LAT+1.
   logic [31:0] m_opa, m_opb, m_sa, m_sb, m_prev;
   logic        m_ovr, m_irq_en, m_have;
   int          m_s;

   task automatic model_reset();
      m_opa = 0; m_opb = 0; m_sa = 0; m_sb = 0; m_prev = 0;
      m_ovr = 0; m_irq_en = 0; m_have = 0; m_s = 0;
   endtask

   function automatic logic m_done(input int t);
      return m_have && (t >= m_s + LAT + 1);
   endfunction

   function automatic logic m_busy(input int t);
      return m_have && (t <= m_s + LAT);
   endfunction

   function automatic logic [31:0] m_result(input int t);
      return m_done(t) ? fmul(m_sa, m_sb) : m_prev;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic model_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] strb,
                              input int c, output logic [1:0] resp);
      resp = 2'b00;
      case (addr)
         5'h00: m_opa = merge(m_opa, d, strb);
         5'h04: m_opb = merge(m_opb, d, strb);
         5'h08: if (strb[0]) begin
`ifdef FPU_MUL_IRQ_EN
            m_irq_en = d[1];
`endif
            if (d[0]) begin
               if (m_have && c <= m_s + LAT + 1) m_ovr = 1'b1;
               else begin
                  m_prev = m_result(c);
                  m_have = 1'b1;
                  m_s    = c;
                  m_sa   = m_opa;
                  m_sb   = m_opb;
               end
            end
         end
         5'h0C: if (strb[0] && d[2]) m_ovr = 1'b0;
         default: resp = 2'b10;
      endcase
   endtask

   task automatic model_read(input logic [4:0] addr, input int t,
                             output logic [31:0] d, output logic [1:0] resp);
      d = 0;
      resp = 2'b00;
      case (addr)
         5'h00: d = m_opa;
         5'h04: d = m_opb;
         5'h08: d = {30'd0, m_irq_en, 1'b0};
         5'h0C: d = {29'd0, m_ovr, m_busy(t), m_done(t)};
         5'h10: d = m_result(t);
         default: resp = 2'b10;
      endcase
   endtask

   task automatic axil_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] strb,
                             input int w_delay, input int b_hold,
                             output logic [1:0] resp, output int commit_cyc);
      logic aw_ok, w_ok, seen;
      aw_ok = 0;
      w_ok  = 0;
      fork
         begin
            axil.awaddr  = addr;
            axil.awvalid = 1'b1;
            for (int i = 0; i < 50 && !aw_ok; i++) begin
               @(negedge clk);
               aw_ok = axil.awready;
               @(posedge clk);
            end
            #1 axil.awvalid = 1'b0;
         end
         begin
            if (w_delay > 0) begin
               repeat (w_delay) @(posedge clk);
               #1;
            end
            axil.wdata  = d;
            axil.wstrb  = strb;
            axil.wvalid = 1'b1;
            for (int i = 0; i < 50 && !w_ok; i++) begin
               @(negedge clk);
               w_ok = axil.wready;
               @(posedge clk);
            end
            #1 axil.wvalid = 1'b0;
         end
      join
      check("aw_accept", 32'(aw_ok), 32'd1);
      check("w_accept", 32'(w_ok), 32'd1);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = axil.bvalid;
      end
      check("bvalid_seen", 32'(seen), 32'd1);
      commit_cyc = cyc;
      resp = axil.bresp;
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         check("bvalid_hold", 32'(axil.bvalid), 32'd1);
         check("bresp_hold", 32'(axil.bresp), 32'(resp));
      end
      axil.bready = 1'b1;
      @(posedge clk);
      #1 axil.bready = 1'b0;
   endtask

   task automatic axil_read(input logic [4:0] addr, output logic [31:0] d,
                            output logic [1:0] resp, output int hs_cyc);
      logic ar_ok, seen;
      ar_ok = 0;
      seen  = 0;
      axil.araddr  = addr;
      axil.arvalid = 1'b1;
      for (int i = 0; i < 50 && !ar_ok; i++) begin
         @(negedge clk);
         ar_ok = axil.arready;
         @(posedge clk);
      end
      #1 axil.arvalid = 1'b0;
      hs_cyc = cyc;
      check("ar_accept", 32'(ar_ok), 32'd1);
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = axil.rvalid;
      end
      check("rvalid_seen", 32'(seen), 32'd1);
      d    = axil.rdata;
      resp = axil.rresp;
      axil.rready = 1'b1;
      @(posedge clk);
      #1 axil.rready = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] strb,
                           input int w_delay, input int b_hold, output int c);
      logic [1:0] resp, exp_resp;
      axil_write(addr, d, strb, w_delay, b_hold, resp, c);
      model_write(addr, d, strb, c, exp_resp);
      $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%0d", addr, d, strb, resp);
      check("bresp", 32'(resp), 32'(exp_resp));
   endtask

   task automatic do_read(input logic [4:0] addr);
      logic [31:0] d, exp_d;
      logic [1:0]  resp, exp_resp;
      int          h;
      axil_read(addr, d, resp, h);
      model_read(addr, h - 1, exp_d, exp_resp);
      $display("RD addr=0x%02h data=0x%08h rresp=%0d", addr, d, resp);
      check($sformatf("rdata@%02h", addr), d, exp_d);
      check("rresp", 32'(resp), 32'(exp_resp));
   endtask

   task automatic check_ports();
      check("op_a", op_a, m_have ? m_sa : 32'd0);
      check("op_b", op_b, m_have ? m_sb : 32'd0);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          c, c2;
      logic [31:0] d;
      logic [1:0]  resp;
      int          h;

      axil.awaddr = 0; axil.awvalid = 0; axil.wdata = 0; axil.wstrb = 0; axil.wvalid = 0;
      axil.bready = 0; axil.araddr = 0; axil.arvalid = 0; axil.rready = 0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", 32'(axil.awready), 32'd0);
      check("rst_wready", 32'(axil.wready), 32'd0);
      check("rst_arready", 32'(axil.arready), 32'd0);
      check("rst_bvalid", 32'(axil.bvalid), 32'd0);
      check("rst_rvalid", 32'(axil.rvalid), 32'd0);
      check("rst_rdata", axil.rdata, 32'd0);
      check_ports();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_read(5'h0C);

      // 2.0 * 3.0; STATUS read exactly at the first DONE edge.
      do_write(5'h00, 32'h4000_0000, 4'hF, 0, 0, c);
      do_write(5'h04, 32'h4040_0000, 4'hF, 0, 0, c);
      do_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, c);
      wait_cyc(c + LAT + 1);
      axil_read(5'h0C, d, resp, h);
      check("done_edge_status", d, (h - 1 == c + LAT + 1) ? 32'h1 : {29'd0, m_ovr, m_busy(h-1), m_done(h-1)});
      axil_read(5'h10, d, resp, h);
      check("result_2x3", d, 32'h40C0_0000);
      check_ports();

      // AW leads W by 3 cycles, B held off for 4 cycles.
      do_write(5'h00, 32'h3FC0_0000, 4'hF, 3, 4, c);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bvalid_after_b", 32'(axil.bvalid), 32'd0);
      end
      @(posedge clk);
      #1;
      do_read(5'h00);

      // Back-to-back START: second one overruns; last busy edge checked too.
      do_write(5'h08, 32'h0000_0001, 4'h1, 0, 0, c);
      do_write(5'h08, 32'h0000_0001, 4'h1, 0, 0, c2);
      check("ovr_set", 32'(m_ovr), 32'd1);
      wait_cyc(c + LAT);
      do_read(5'h0C);
      wait_cyc(c + LAT + 2);
      do_read(5'h10);
      check("result_1p5x3", m_result(cyc), 32'h4090_0000);
      do_read(5'h0C);
      do_write(5'h0C, 32'h0000_0004, 4'h1, 0, 0, c);
      do_read(5'h0C);

      // OPA rewritten while running: the shadow must not move.
      do_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, c);
      do_write(5'h00, 32'h3F80_0000, 4'hF, 0, 0, c2);
      check_ports();
      wait_cyc(c + LAT + 2);
      do_read(5'h10);
      check_ports();

      // Unmapped read, RESULT write.
      do_read(5'h14);
      do_write(5'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, c);
      do_read(5'h10);

      for (int it = 0; it < 80; it++) begin
         int          r;
         logic [3:0]  strb;
         logic [4:0]  addr;
         r    = $urandom_range(0, 9);
         strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
         case (r)
            0, 1: do_write(5'h00, rand_fp(), strb, $urandom_range(0, 2), $urandom_range(0, 2), c);
            2, 3: do_write(5'h04, rand_fp(), strb, $urandom_range(0, 2), $urandom_range(0, 2), c);
            4: do_write(5'h08, {30'($urandom), 2'($urandom_range(0, 3))}, strb,
                        $urandom_range(0, 2), 0, c);
            5: do_write(5'h0C, 32'($urandom), 4'hF, 0, 0, c);
            6: begin
               addr = 5'(5'h10 + 5'($urandom_range(0, 3) * 4));
               do_write(addr, 32'($urandom), 4'hF, 0, 0, c);
            end
            default: begin
               addr = 5'($urandom_range(0, 7) * 4);
               do_read(addr);
            end
         endcase
         check_ports();
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
      end

      // Reset in the middle of an operation.
      wait_cyc(cyc + LAT + 2);
      do_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, c);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_op_a", op_a, 32'd0);
      check("midrst_op_b", op_b, 32'd0);
      check("midrst_arready", 32'(axil.arready), 32'd0);
      check("midrst_rvalid", 32'(axil.rvalid), 32'd0);
      check("midrst_bvalid", 32'(axil.bvalid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_read(5'h0C);
      do_write(5'h00, 32'h4000_0000, 4'hF, 0, 0, c);
      do_write(5'h04, 32'h4080_0000, 4'hF, 0, 0, c);
      do_write(5'h08, 32'h0000_0001, 4'hF, 0, 0, c);
      wait_cyc(c + LAT + 2);
      do_read(5'h0C);
      do_read(5'h10);
      check("result_2x4", m_result(cyc), 32'h4100_0000);
      check_ports();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
